// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline register bank: bubble encoding,
// per-stage load selection and small width/count helpers.
package pipe_ctrl_pkg;

  // Upper bound on STAGES accepted by the popcount helper.
  localparam int MAX_STAGES = 64;

  // A bubble is an invalid entry whose payload is forced to zero.
  localparam logic BUBBLE_VLD = 1'b0;

  // What a stage register captures on the next enabled edge.
  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_LOAD   = 2'd1,
    SEL_SHIFT  = 2'd2,
    SEL_BUBBLE = 2'd3
  } stage_sel_e;

  // Index width for addressing STAGES entries, never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of set bits in a valid vector (caller zero-extends).
  function automatic int unsigned popcount(input logic [MAX_STAGES-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: step only when enabled, requested and not yet saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en && inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Parametrised pipeline register bank with per-stage valid bits, stall with
// bubble insertion behind the frozen stages, and partial flush of the young end.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STAGES   = 4,
  parameter int STALL_AT = 0,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = idx_w(STAGES)
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     stall_req,
  input  logic                     flush_req,
  input  logic [IDX_W-1:0]         flush_upto,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W:0]           occupancy,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam int OCC_W = IDX_W + 1;
  // A stall point at the last stage freezes the whole bank with no bubble.
  localparam bit STALL_MAKES_BUBBLE = (STALL_AT < STAGES - 1);

  stage_sel_e sel [STAGES];
  int         flush_lim;

  // Per-stage load selection; priority flush > stall > advance, all gated by enable.
  always_comb begin
    flush_lim = int'(flush_upto);
    if (flush_lim > STAGES - 1) begin
      flush_lim = STAGES - 1;
    end
    for (int k = 0; k < STAGES; k++) begin
      sel[k] = SEL_HOLD;
      if (enable) begin
        if (flush_req) begin
          // Squashed stages plus the one behind them become bubbles; older ones move on.
          sel[k] = (k <= flush_lim + 1) ? SEL_BUBBLE : SEL_SHIFT;
        end else if (stall_req) begin
          if (!STALL_MAKES_BUBBLE || k <= STALL_AT) begin
            sel[k] = SEL_HOLD;
          end else if (k == STALL_AT + 1) begin
            sel[k] = SEL_BUBBLE;
          end else begin
            sel[k] = SEL_SHIFT;
          end
        end else begin
          sel[k] = (k == 0) ? SEL_LOAD : SEL_SHIFT;
        end
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              vld_d, vld_q;
    logic [DATA_W-1:0] dat_d, dat_q;
    logic              prev_vld;
    logic [DATA_W-1:0] prev_dat;

    if (k == 0) begin : g_head
      // An invalid input enters as a bubble with its payload zeroed.
      assign prev_vld = in_valid;
      assign prev_dat = in_valid ? in_data : '0;
    end else begin : g_body
      assign prev_vld = stage_valid[k-1];
      assign prev_dat = stage_data[(k-1)*DATA_W +: DATA_W];
    end

    // Stage next-state from the selection made above.
    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      case (sel[k])
        SEL_BUBBLE: begin
          vld_d = BUBBLE_VLD;
          dat_d = '0;
        end
        SEL_LOAD, SEL_SHIFT: begin
          vld_d = prev_vld;
          dat_d = prev_dat;
        end
        default: ;
      endcase
    end

    // Stage register; reset clears both valid and payload.
    always_ff @(posedge clk) begin
      if (srst) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign stage_valid[k]                = vld_q;
    assign stage_data[k*DATA_W +: DATA_W] = dat_q;
  end

  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[(STAGES-1)*DATA_W +: DATA_W];
  assign occupancy = OCC_W'(popcount(MAX_STAGES'(stage_valid)));

  // Input is taken whenever the bank moves at the young end; during a flush it is taken and dropped.
  assign in_ready = enable & (~stall_req | flush_req);

  logic bubble_inc;
  logic flush_inc;

  assign bubble_inc = stall_req & ~flush_req & STALL_MAKES_BUBBLE;
  assign flush_inc  = flush_req;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk  (clk),
    .srst (srst),
    .en   (enable),
    .inc  (bubble_inc),
    .cnt  (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .srst (srst),
    .en   (enable),
    .inc  (flush_inc),
    .cnt  (flush_cnt)
  );

endmodule
